// File: rtl/sm_noc_tx.sv
// CPU-to-router transmit port for the schoolMIPS NoC: frames CPU words as flits
// {data, last, dest}, buffers them in a FIFO and hands them to the router on Outw/Inr.
module sm_noc_tx #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 4,
    parameter  int DEPTH  = 4,
    localparam int FLIT_W = DATA_W + 1 + ADDR_W,
    localparam int PW     = $clog2(DEPTH),
    localparam int LW     = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic [ADDR_W-1:0] cpu_dest,
    input  logic              cpu_last,
    input  logic              cpu_send,
    output logic              cpu_busy,
    output logic              cpu_err,
    input  logic              cpu_err_clr,
    output logic              cpu_in_pkt,
    output logic [LW-1:0]     level,
    output logic [FLIT_W-1:0] flit_out,
    output logic              Outw,
    input  logic              Inr
);

    typedef enum logic {IDLE, IN_PKT} pktState_t;

    pktState_t         stateQ, stateD;
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrPtr, rdPtr;
    logic [ADDR_W-1:0] destQ, flitDest;
    logic              full, push, pop, overflow;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot for a push.
    assign full     = (level == LW'(DEPTH));
    assign cpu_busy = full;
    assign push     = cpu_send && !full;
    assign overflow = cpu_send && full;
    assign Outw     = (level != '0);
    assign pop      = Outw && Inr;
    assign flit_out = Outw ? mem[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr] <= {cpu_data, cpu_last, flitDest};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            level   <= '0;
            cpu_err <= 1'b0;
            destQ   <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PW'(1);
            if (pop)
                rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // Set wins over clear.
            if (overflow)
                cpu_err <= 1'b1;
            else if (cpu_err_clr)
                cpu_err <= 1'b0;
            if (push && stateQ == IDLE && !cpu_last)
                destQ <= cpu_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            stateQ <= IDLE;
        else
            stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (push && !cpu_last) stateD = IN_PKT;
            IN_PKT:  if (push && cpu_last)  stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Destination is locked to the first flit's address for the rest of the packet.
    always_comb begin
        cpu_in_pkt = (stateQ == IN_PKT);
        flitDest   = (stateQ == IN_PKT) ? destQ : cpu_dest;
    end

endmodule

// File: tb/tb_sm_noc_tx.sv
// Directed bench for sm_noc_tx: framing, packet dest locking, FIFO full/empty, errors, reset.
module tb_sm_noc_tx;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int D  = 4;
    localparam int FW = DW + 1 + AW;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] cpu_data = '0;
    logic [AW-1:0] cpu_dest = '0;
    logic          cpu_last = 1'b0;
    logic          cpu_send = 1'b0;
    logic          cpu_busy;
    logic          cpu_err;
    logic          cpu_err_clr = 1'b0;
    logic          cpu_in_pkt;
    logic [LW-1:0] level;
    logic [FW-1:0] flit_out;
    logic          Outw;
    logic          Inr = 1'b0;

    int errors = 0;
    int checks = 0;

    sm_noc_tx #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .cpu_data(cpu_data), .cpu_dest(cpu_dest),
        .cpu_last(cpu_last), .cpu_send(cpu_send), .cpu_busy(cpu_busy),
        .cpu_err(cpu_err), .cpu_err_clr(cpu_err_clr), .cpu_in_pkt(cpu_in_pkt),
        .level(level), .flit_out(flit_out), .Outw(Outw), .Inr(Inr)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic send, input logic last, input logic [AW-1:0] dest,
                         input logic [DW-1:0] data);
        cpu_send = send;
        cpu_last = last;
        cpu_dest = dest;
        cpu_data = data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        tick();
        checks++; if (Outw !== 1'b0) begin errors++; $display("FAIL reset_outw got=%0h exp=0", Outw); end
        checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit got=%0h exp=0", flit_out); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", cpu_busy); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", cpu_err); end
        checks++; if (cpu_in_pkt !== 1'b0) begin errors++; $display("FAIL reset_inpkt got=%0h exp=0", cpu_in_pkt); end
        reset = 1'b1;
    endtask

    task automatic test_single_flit();
        logic [FW-1:0] exp;
        exp = {32'hDEADBEEF, 1'b1, 4'd5};
        Inr = 1'b1;
        drive(1, 1, 4'd5, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (Outw !== 1'b1) begin errors++; $display("FAIL single_outw got=%0h exp=1", Outw); end
        checks++; if (flit_out !== exp) begin errors++; $display("FAIL single_flit got=%0h exp=%0h", flit_out, exp); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        checks++; if (cpu_in_pkt !== 1'b0) begin errors++; $display("FAIL single_inpkt got=%0h exp=0", cpu_in_pkt); end
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_pop_level got=%0d exp=0", level); end
        checks++; if (Outw !== 1'b0) begin errors++; $display("FAIL single_pop_outw got=%0h exp=0", Outw); end
    endtask

    task automatic test_packet();
        logic [FW-1:0] exp [3];
        exp[0] = {32'hA0000001, 1'b0, 4'd3};
        exp[1] = {32'hA0000002, 1'b0, 4'd3};
        exp[2] = {32'hA0000003, 1'b1, 4'd3};
        Inr = 1'b0;
        drive(1, 0, 4'd3, 32'hA0000001);
        tick();
        checks++; if (cpu_in_pkt !== 1'b1) begin errors++; $display("FAIL pkt_open got=%0h exp=1", cpu_in_pkt); end
        drive(1, 0, 4'd9, 32'hA0000002);
        tick();
        drive(1, 1, 4'd9, 32'hA0000003);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (cpu_in_pkt !== 1'b0) begin errors++; $display("FAIL pkt_close got=%0h exp=0", cpu_in_pkt); end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL pkt_level got=%0d exp=3", level); end
        Inr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (flit_out !== exp[i]) begin errors++; $display("FAIL pkt_flit%0d got=%0h exp=%0h", i, flit_out, exp[i]); end
            tick();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL pkt_drain got=%0d exp=0", level); end
    endtask

    task automatic test_fill_overflow();
        logic [FW-1:0] exp;
        Inr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, AW'(i), DW'(32'h100 + i));
            tick();
            if (i == 3) begin
                checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL fill_busy4 got=%0h exp=1", cpu_busy); end
                checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL fill_err4 got=%0h exp=0", cpu_err); end
            end
        end
        drive(0, 0, 0, 0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got=%0h exp=1", cpu_busy); end
        checks++; if (cpu_err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%0h exp=1", cpu_err); end
        Inr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = {DW'(32'h100 + i), 1'b1, AW'(i)};
            checks++; if (flit_out !== exp) begin errors++; $display("FAIL ovf_flit%0d got=%0h exp=%0h", i, flit_out, exp); end
            tick();
        end
        checks++; if (Outw !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0h exp=0", Outw); end
        // Refill across the pointer wrap.
        Inr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, AW'(i + 8), DW'(32'h200 + i));
            tick();
        end
        drive(0, 0, 0, 0);
        Inr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = {DW'(32'h200 + i), 1'b1, AW'(i + 8)};
            checks++; if (flit_out !== exp) begin errors++; $display("FAIL wrap_flit%0d got=%0h exp=%0h", i, flit_out, exp); end
            tick();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_level got=%0d exp=0", level); end
    endtask

    task automatic test_err_clr();
        Inr = 1'b0;
        cpu_err_clr = 1'b1;
        tick();
        cpu_err_clr = 1'b0;
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL clr_alone got=%0h exp=0", cpu_err); end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'd1, DW'(i));
            tick();
        end
        cpu_err_clr = 1'b1;
        drive(1, 1, 4'd1, 32'h55);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (cpu_err !== 1'b1) begin errors++; $display("FAIL clr_vs_set got=%0h exp=1", cpu_err); end
        tick();
        cpu_err_clr = 1'b0;
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL clr_again got=%0h exp=0", cpu_err); end
        Inr = 1'b1;
        repeat (4) tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL clr_drain got=%0d exp=0", level); end
    endtask

    task automatic test_push_pop();
        logic [FW-1:0] exp;
        Inr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 4'd2, DW'(32'h300 + i));
            tick();
        end
        Inr = 1'b1;
        drive(1, 1, 4'd2, 32'h302);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL pp_level got=%0d exp=2", level); end
        for (int i = 1; i < 3; i++) begin
            exp = {DW'(32'h300 + i), 1'b1, 4'd2};
            checks++; if (flit_out !== exp) begin errors++; $display("FAIL pp_flit%0d got=%0h exp=%0h", i, flit_out, exp); end
            tick();
        end
        // Push while full with a coincident pop must still be rejected.
        Inr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'd4, DW'(32'h400 + i));
            tick();
        end
        Inr = 1'b1;
        drive(1, 1, 4'd4, 32'h404);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL ppfull_level got=%0d exp=3", level); end
        checks++; if (cpu_err !== 1'b1) begin errors++; $display("FAIL ppfull_err got=%0h exp=1", cpu_err); end
        for (int i = 1; i < 4; i++) begin
            exp = {DW'(32'h400 + i), 1'b1, 4'd4};
            checks++; if (flit_out !== exp) begin errors++; $display("FAIL ppfull_flit%0d got=%0h exp=%0h", i, flit_out, exp); end
            tick();
        end
        checks++; if (Outw !== 1'b0) begin errors++; $display("FAIL ppfull_empty got=%0h exp=0", Outw); end
        cpu_err_clr = 1'b1;
        tick();
        cpu_err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        logic [FW-1:0] exp;
        Inr = 1'b0;
        drive(1, 0, 4'd7, 32'h500);
        tick();
        drive(1, 0, 4'd1, 32'h501);
        tick();
        drive(1, 0, 4'd1, 32'h502);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level got=%0d exp=3", level); end
        checks++; if (cpu_in_pkt !== 1'b1) begin errors++; $display("FAIL mid_inpkt got=%0h exp=1", cpu_in_pkt); end
        reset = 1'b0;
        tick();
        checks++; if (Outw !== 1'b0) begin errors++; $display("FAIL mid_rst_outw got=%0h exp=0", Outw); end
        checks++; if (flit_out !== '0) begin errors++; $display("FAIL mid_rst_flit got=%0h exp=0", flit_out); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
        checks++; if (cpu_in_pkt !== 1'b0) begin errors++; $display("FAIL mid_rst_inpkt got=%0h exp=0", cpu_in_pkt); end
        checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%0h exp=0", cpu_busy); end
        reset = 1'b1;
        drive(1, 1, 4'd2, 32'h600);
        tick();
        drive(0, 0, 0, 0);
        exp = {32'h600, 1'b1, 4'd2};
        checks++; if (flit_out !== exp) begin errors++; $display("FAIL mid_next_flit got=%0h exp=%0h", flit_out, exp); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL mid_next_level got=%0d exp=1", level); end
        checks++; if (cpu_in_pkt !== 1'b0) begin errors++; $display("FAIL mid_next_inpkt got=%0h exp=0", cpu_in_pkt); end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_packet();
        test_fill_overflow();
        test_err_clr();
        test_push_pop();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
